// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op bit positions, inter-stage bundle
// widths and the divider state encoding.
package pipeline_pkg;

    // One-hot alu_op bit positions
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_MULH  = 13;
    localparam int ALU_MULHU = 14;
    localparam int ALU_DIV   = 15;
    localparam int ALU_DIVU  = 16;
    localparam int ALU_MOD   = 17;
    localparam int ALU_MODU  = 18;
    localparam int ALU_OP_W  = 19;

    // Inter-stage bundle widths
    localparam int ID2EX_W  = 155;
    localparam int EX2MEM_W = 71;
    localparam int EX_ZIP_W = 39;

    // Divider sequencing
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// 32-bit restoring divider with IDLE/RUN/DONE sequencing. Works on operand
// magnitudes and applies the sign fixup on the way out. The current state
// is exported so the stage (and any bound checker) can observe it.
module div_unit
    import pipeline_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output div_state_e  state
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvsr_q;
    logic [31:0]      dividend_raw_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             div0_q;

    logic        s1_neg;
    logic        s2_neg;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        borrow;

    assign s1_neg = is_signed & dividend[31];
    assign s2_neg = is_signed & divisor[31];
    assign abs1   = s1_neg ? (~dividend + 32'd1) : dividend;
    assign abs2   = s2_neg ? (~divisor + 32'd1) : divisor;

    // quo_q starts as the dividend: its MSB feeds the partial remainder while
    // quotient bits shift in from the bottom.
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_sub = rem_sh - {1'b0, dvsr_q};
    assign borrow  = rem_sub[32];

    // Divider sequencing and one restoring iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= DIV_IDLE;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvsr_q         <= '0;
            dividend_raw_q <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            div0_q         <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state          <= DIV_RUN;
                        cnt            <= '0;
                        rem_q          <= '0;
                        quo_q          <= abs1;
                        dvsr_q         <= abs2;
                        dividend_raw_q <= dividend;
                        q_neg_q        <= s1_neg ^ s2_neg;
                        r_neg_q        <= s1_neg;
                        div0_q         <= (divisor == 32'd0);
                    end
                end
                DIV_RUN: begin
                    cnt   <= cnt + CNT_W'(1);
                    rem_q <= borrow ? rem_sh[31:0] : rem_sub[31:0];
                    quo_q <= {quo_q[30:0], ~borrow};
                    if (cnt == LAST) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign done = (state == DIV_DONE);

    // Divide-by-zero overrides the sign fixup for every op variant
    assign quotient  = div0_q  ? 32'hFFFF_FFFF :
                       q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = div0_q  ? dividend_raw_q :
                       r_neg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, single-cycle multiplier, iterative divider, data-SRAM
// request issue and the forwarding/stall bundle back to decode.
//
// Handshake: an instruction moves from decode into EX on an edge where
// id_to_ex_valid & ex_allowin; it leaves EX on an edge where
// ex_to_mem_valid & mem_allowin. ex_allowin = ~ex_valid | (ex_ready_go &
// mem_allowin), so EX holds its bundle unchanged while it is stalled.
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ex_allowin,
    input  logic                id_to_ex_valid,
    input  logic [ID2EX_W-1:0]  id_to_ex_wire,
    input  logic                mem_allowin,
    output logic                ex_to_mem_valid,
    output logic [EX2MEM_W-1:0] ex_to_mem_wire,
    output logic [EX_ZIP_W-1:0] ex_rf_zip,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata
);

    logic               ex_valid;
    logic               ex_ready_go;
    logic [ID2EX_W-1:0] bundle_q;

    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] rkd_value;
    logic        res_from_mem;

    assign {alu_op, src1, src2, rf_we, rf_waddr, pc, mem_we, rkd_value, res_from_mem} = bundle_q;

    // Stage occupancy and decode bundle capture
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (ex_allowin) begin
                ex_valid <= id_to_ex_valid;
            end
            if (id_to_ex_valid && ex_allowin) begin
                bundle_q <= id_to_ex_wire;
            end
        end
    end

    // ---------------- ALU and multiplier ----------------
    logic [4:0]  shamt;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sra_res;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic        mul_signed;

    assign shamt    = src2[4:0];
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sra_res  = $signed(src1) >>> shamt;

    // 33-bit operands (sign- or zero-extended by op) widened to 64 bits; the
    // low 64 product bits are all any multiply op needs.
    assign mul_signed = alu_op[ALU_MULH];
    assign mul_a      = {{32{mul_signed & src1[31]}}, src1};
    assign mul_b      = {{32{mul_signed & src2[31]}}, src2};
    assign prod       = mul_a * mul_b;

    // ---------------- divider ----------------
    logic        div_op;
    logic        div_signed;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    div_state_e  div_state;

    assign div_op     = |alu_op[ALU_MODU:ALU_DIV];
    assign div_signed = alu_op[ALU_DIV] | alu_op[ALU_MOD];

    div_unit #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_valid & div_op),
        .is_signed (div_signed),
        .dividend  (src1),
        .divisor   (src2),
        .ack       (mem_allowin),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .state     (div_state)
    );

    // One-hot result select; an all-zero op yields zero
    logic [31:0] result;
    always_comb begin
        result = 32'd0;
        if (alu_op[ALU_ADD])   result = result | (src1 + src2);
        if (alu_op[ALU_SUB])   result = result | (src1 - src2);
        if (alu_op[ALU_SLT])   result = result | slt_res;
        if (alu_op[ALU_SLTU])  result = result | sltu_res;
        if (alu_op[ALU_AND])   result = result | (src1 & src2);
        if (alu_op[ALU_NOR])   result = result | ~(src1 | src2);
        if (alu_op[ALU_OR])    result = result | (src1 | src2);
        if (alu_op[ALU_XOR])   result = result | (src1 ^ src2);
        if (alu_op[ALU_SLL])   result = result | (src1 << shamt);
        if (alu_op[ALU_SRL])   result = result | (src1 >> shamt);
        if (alu_op[ALU_SRA])   result = result | sra_res;
        if (alu_op[ALU_LUI])   result = result | src2;
        if (alu_op[ALU_MUL])   result = result | prod[31:0];
        if (alu_op[ALU_MULH])  result = result | prod[63:32];
        if (alu_op[ALU_MULHU]) result = result | prod[63:32];
        if (alu_op[ALU_DIV])   result = result | div_quo;
        if (alu_op[ALU_DIVU])  result = result | div_quo;
        if (alu_op[ALU_MOD])   result = result | div_rem;
        if (alu_op[ALU_MODU])  result = result | div_rem;
    end

    // ---------------- handshake and outputs ----------------
    assign ex_ready_go     = ~div_op | div_done;
    assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
    assign ex_to_mem_valid = ex_valid & ex_ready_go;
    assign ex_to_mem_wire  = {res_from_mem, rf_we, rf_waddr, pc, result};

    // The request fires only in the handoff cycle, so each memory op issues once
    assign data_sram_en    = ex_valid & ex_ready_go & mem_allowin & (res_from_mem | mem_we);
    assign data_sram_we    = {4{mem_we}} & {4{data_sram_en}};
    assign data_sram_addr  = result;
    assign data_sram_wdata = rkd_value;

    assign ex_rf_zip = {ex_valid & (res_from_mem | (div_op & (div_state != DIV_DONE))),
                        ex_valid & rf_we,
                        rf_waddr,
                        result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of single-instruction vectors with
// hand-computed results and latencies, plus hand-written sequences for the
// store back-pressure and reset-during-divide cases.
module tb_ex_stage;
    import pipeline_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                ex_allowin;
    logic                id_to_ex_valid;
    logic [ID2EX_W-1:0]  id_to_ex_wire;
    logic                mem_allowin;
    logic                ex_to_mem_valid;
    logic [EX2MEM_W-1:0] ex_to_mem_wire;
    logic [EX_ZIP_W-1:0] ex_rf_zip;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;

    ex_stage #(.DIV_ITERS(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_allowin      (ex_allowin),
        .id_to_ex_valid  (id_to_ex_valid),
        .id_to_ex_wire   (id_to_ex_wire),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_wire  (ex_to_mem_wire),
        .ex_rf_zip       (ex_rf_zip),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ALU_OP_W-1:0] oh(input int idx);
        logic [ALU_OP_W-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID2EX_W-1:0] mk_bundle(
        input logic [ALU_OP_W-1:0] op, input logic [31:0] s1, input logic [31:0] s2,
        input logic we, input logic [4:0] waddr, input logic [31:0] pc,
        input logic mwe, input logic [31:0] rkd, input logic rmem);
        return {op, s1, s2, we, waddr, pc, mwe, rkd, rmem};
    endfunction

    // Present one bundle for one edge; returns #1 into EX cycle 1
    task automatic issue(input logic [ID2EX_W-1:0] b);
        id_to_ex_wire  = b;
        id_to_ex_valid = 1'b1;
        step();
        id_to_ex_valid = 1'b0;
        id_to_ex_wire  = '0;
    endtask

    typedef struct {
        string       name;
        logic [ALU_OP_W-1:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk_vec(input string n, input int op_idx, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] e, input int l);
        vec_t v;
        v.name = n; v.op = oh(op_idx); v.s1 = a; v.s2 = b; v.exp = e; v.lat = l;
        return v;
    endfunction

    // Issue a vector, wait (bounded) for the result, then hand it off
    task automatic run_vec(input vec_t v);
        logic [31:0] got;
        logic [31:0] exp;
        int lat;
        int bad_flags;
        bit seen;
        got = '0; lat = 0; bad_flags = 0; seen = 1'b0;
        check({v.name, "_allowin_before"}, 64'(ex_allowin), 64'd1);
        exp_q.push_back(v.exp);
        issue(mk_bundle(v.op, v.s1, v.s2, 1'b1, 5'd9, 32'h1c00_0040, 1'b0, 32'd0, 1'b0));
        for (int c = 1; c <= 100; c++) begin
            if (ex_to_mem_valid) begin
                lat  = c;
                got  = ex_to_mem_wire[31:0];
                seen = 1'b1;
                break;
            end
            // Still computing: decode must see not-ready and EX must be closed
            if (ex_rf_zip[38] !== 1'b1 || ex_allowin !== 1'b0) bad_flags++;
            step();
        end
        exp = exp_q.pop_front();
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ex_to_mem_valid within 100 cycles", v.name);
        end else begin
            check(v.name, 64'(got), 64'(exp));
            check({v.name, "_lat"}, 64'(lat), 64'(v.lat));
            if (v.lat > 1) begin
                check({v.name, "_stall_flags"}, 64'(bad_flags), 64'd0);
                check({v.name, "_not_ready_done"}, 64'(ex_rf_zip[38]), 64'd0);
            end
        end
        step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int pulses;

        vecs.push_back(mk_vec("sub",      ALU_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1));
        vecs.push_back(mk_vec("slt_t",    ALU_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1));
        vecs.push_back(mk_vec("slt_f",    ALU_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,         1));
        vecs.push_back(mk_vec("sltu_f",   ALU_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1));
        vecs.push_back(mk_vec("sltu_t",   ALU_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,         1));
        vecs.push_back(mk_vec("and",      ALU_AND,   32'hFF00_FF00, 32'hF0F0_F0F0, 32'hF000_F000, 1));
        vecs.push_back(mk_vec("nor",      ALU_NOR,   32'd0,         32'd0,         32'hFFFF_FFFF, 1));
        vecs.push_back(mk_vec("or",       ALU_OR,    32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1));
        vecs.push_back(mk_vec("xor",      ALU_XOR,   32'hFF00_FF00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1));
        vecs.push_back(mk_vec("sll",      ALU_SLL,   32'd1,         32'hFFFF_FFE1, 32'd2,         1));
        vecs.push_back(mk_vec("sll31",    ALU_SLL,   32'd1,         32'd31,        32'h8000_0000, 1));
        vecs.push_back(mk_vec("srl",      ALU_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 1));
        vecs.push_back(mk_vec("sra",      ALU_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 1));
        vecs.push_back(mk_vec("lu12i",    ALU_LUI,   32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1));
        vecs.push_back(mk_vec("op_none",  -1,        32'd5,         32'd7,         32'd0,         1));
        vecs.push_back(mk_vec("mul_w",    ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1));
        vecs.push_back(mk_vec("mul_w2",   ALU_MUL,   32'h1234_5678, 32'h10,        32'h2345_6780, 1));
        vecs.push_back(mk_vec("mulh_w",   ALU_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1));
        vecs.push_back(mk_vec("mulh_w2",  ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1));
        vecs.push_back(mk_vec("mulh_wu",  ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1));
        vecs.push_back(mk_vec("mulh_wu2", ALU_MULHU, 32'h8000_0000, 32'd2,         32'h0000_0001, 1));
        vecs.push_back(mk_vec("div_w",    ALU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34));
        vecs.push_back(mk_vec("mod_w",    ALU_MOD,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34));
        vecs.push_back(mk_vec("div_wu_0", ALU_DIVU,  32'd100,       32'd0,         32'hFFFF_FFFF, 34));
        vecs.push_back(mk_vec("mod_wu_0", ALU_MODU,  32'd100,       32'd0,         32'd100,       34));
        vecs.push_back(mk_vec("div_w_ovf",ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34));
        vecs.push_back(mk_vec("mod_w_ovf",ALU_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34));
        vecs.push_back(mk_vec("div_wu",   ALU_DIVU,  32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34));
        vecs.push_back(mk_vec("mod_wu",   ALU_MODU,  32'd7,         32'd3,         32'd1,         34));
        vecs.push_back(mk_vec("div_w_ng", ALU_DIV,   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34));
        vecs.push_back(mk_vec("mod_w_ng", ALU_MOD,   32'd100,       32'hFFFF_FFF9, 32'd2,         34));
        vecs.push_back(mk_vec("div_w_0",  ALU_DIV,   32'd0,         32'd0,         32'hFFFF_FFFF, 34));
        vecs.push_back(mk_vec("mod_w_0",  ALU_MOD,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 34));

        // Reset
        reset          = 1'b1;
        id_to_ex_valid = 1'b0;
        id_to_ex_wire  = '0;
        mem_allowin    = 1'b1;
        step();
        step();
        check("rst_allowin",   64'(ex_allowin),      64'd1);
        check("rst_to_mem_v",  64'(ex_to_mem_valid), 64'd0);
        check("rst_sram_en",   64'(data_sram_en),    64'd0);
        check("rst_sram_we",   64'(data_sram_we),    64'd0);
        check("rst_zip",       64'(ex_rf_zip),       64'd0);
        check("rst_div_state", 64'(dut.u_div.state), 64'(DIV_IDLE));
        reset = 1'b0;
        step();

        // add_w with full bundle/zip check
        issue(mk_bundle(oh(ALU_ADD), 32'd5, 32'd7, 1'b1, 5'd3, 32'h1c00_0000, 1'b0, 32'd0, 1'b0));
        check("add_to_mem_v", 64'(ex_to_mem_valid), 64'd1);
        check("add_wire",     64'(ex_to_mem_wire),  64'({1'b0, 1'b1, 5'd3, 32'h1c00_0000, 32'd12}));
        check("add_zip",      64'(ex_rf_zip),       64'({1'b0, 1'b1, 5'd3, 32'd12}));
        check("add_sram_en",  64'(data_sram_en),    64'd0);
        step();
        check("add_drained",  64'(ex_to_mem_valid), 64'd0);

        // Table vectors
        foreach (vecs[i]) run_vec(vecs[i]);

        // st_w under back-pressure: one request, only when MEM accepts
        mem_allowin = 1'b0;
        pulses = 0;
        issue(mk_bundle(oh(ALU_ADD), 32'h0000_1000, 32'd0, 1'b0, 5'd0, 32'h1c00_0100,
                        1'b1, 32'hDEAD_BEEF, 1'b0));
        // Decode tries to push another instruction into the stalled stage
        id_to_ex_wire  = mk_bundle(oh(ALU_ADD), 32'h5555_0000, 32'd1, 1'b1, 5'd7, 32'h1c00_0104,
                                   1'b0, 32'd0, 1'b0);
        id_to_ex_valid = 1'b1;
        #1;
        for (int c = 1; c <= 3; c++) begin
            if (data_sram_en) pulses++;
            check($sformatf("st_stall_en_c%0d", c),      64'(data_sram_en),   64'd0);
            check($sformatf("st_stall_allowin_c%0d", c), 64'(ex_allowin),     64'd0);
            check($sformatf("st_stall_addr_c%0d", c),    64'(data_sram_addr), 64'h1000);
            step();
        end
        id_to_ex_valid = 1'b0;
        id_to_ex_wire  = '0;
        mem_allowin    = 1'b1;
        #1;
        if (data_sram_en) pulses++;
        check("st_en",    64'(data_sram_en),    64'd1);
        check("st_we",    64'(data_sram_we),    64'hF);
        check("st_addr",  64'(data_sram_addr),  64'h1000);
        check("st_wdata", 64'(data_sram_wdata), 64'hDEAD_BEEF);
        step();
        if (data_sram_en) pulses++;
        step();
        if (data_sram_en) pulses++;
        check("st_pulses", 64'(pulses), 64'd1);

        // ld_w: request with no write enables, decode told to wait
        issue(mk_bundle(oh(ALU_ADD), 32'h0000_2000, 32'd4, 1'b1, 5'd12, 32'h1c00_0200,
                        1'b0, 32'd0, 1'b1));
        check("ld_en",        64'(data_sram_en),   64'd1);
        check("ld_we",        64'(data_sram_we),   64'h0);
        check("ld_addr",      64'(data_sram_addr), 64'h2004);
        check("ld_not_ready", 64'(ex_rf_zip[38]),  64'd1);
        step();
        check("ld_en_after",  64'(data_sram_en),   64'd0);

        // Reset in EX cycle 10 of a div_w discards it
        issue(mk_bundle(oh(ALU_DIV), 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd4, 32'h1c00_0300,
                        1'b0, 32'd0, 1'b0));
        for (int c = 1; c < 10; c++) step();
        check("mid_div_running", 64'(dut.u_div.state), 64'(DIV_RUN));
        reset = 1'b1;
        step();
        check("rdiv_to_mem_v", 64'(ex_to_mem_valid), 64'd0);
        check("rdiv_allowin",  64'(ex_allowin),      64'd1);
        check("rdiv_zip_ctl",  64'(ex_rf_zip[38:37]), 64'd0);
        check("rdiv_state",    64'(dut.u_div.state), 64'(DIV_IDLE));
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (ex_to_mem_valid) pulses++;
            step();
        end
        check("rdiv_no_result", 64'(pulses), 64'd0);
        run_vec(mk_vec("div_after_rst", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34));

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
